// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-stage definitions: reset PC, FSM state encoding and PC alignment helper.
// The hazard unit and benches reuse these encodings.
package fetch_sequencer_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus bundle: instruction-memory request/return, IF/ID delivery and decode redirect.
interface fetch_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;

  logic        fd_valid;
  logic [31:0] fd_pc;
  logic [31:0] fd_instr;
  logic        fd_stall;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, fd_valid, fd_pc, fd_instr,
    input  imem_rdy, imem_rdata, fd_stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, fd_valid, fd_pc, fd_instr,
    output imem_rdy, imem_rdata, fd_stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_sequencer_redirect_buf.sv
// Holds a decode redirect that could not be applied yet because the delay-slot
// instruction has not transferred; a later redirect overwrites (last wins).
module fetch_sequencer_redirect_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic [31:0] capture_pc,
  input  logic        consume,
  output logic        pend_valid,
  output logic [31:0] pend_pc
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else if (consume) begin
      // A transfer in the same cycle uses the redirect directly, so nothing is kept.
      pend_valid <= 1'b0;
    end else if (capture) begin
      pend_valid <= 1'b1;
      pend_pc    <= capture_pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, issues one imem request per PC and delivers
// {pc, instr} to IF/ID, applying decode redirects after the delay slot.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  fetch_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  hold_pc;
  logic [31:0]  hold_instr;
  logic         transfer;
  logic         capture_hold;
  logic         pend_valid;
  logic [31:0]  pend_pc;
  logic [31:0]  next_pc;

  fetch_sequencer_redirect_buf u_redirect_buf (
    .clk        (clk),
    .reset      (reset),
    .capture    (bus.redirect_valid),
    .capture_pc (bus.redirect_pc),
    .consume    (transfer),
    .pend_valid (pend_valid),
    .pend_pc    (pend_pc)
  );

  // A buffered redirect belongs to an older branch than one arriving now.
  assign next_pc = align_pc(pend_valid         ? pend_pc :
                            bus.redirect_valid ? bus.redirect_pc :
                                                 pc_q + 32'd4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    state_d        = state_q;
    bus.imem_req   = 1'b0;
    bus.imem_addr  = pc_q;
    bus.fd_valid   = 1'b0;
    bus.fd_pc      = pc_q;
    bus.fd_instr   = bus.imem_rdata;
    transfer       = 1'b0;
    capture_hold   = 1'b0;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        bus.imem_req = 1'b1;
        bus.fd_valid = bus.imem_rdy;
        if (bus.imem_rdy) begin
          if (bus.fd_stall) begin
            capture_hold = 1'b1;
            state_d      = HOLD;
          end else begin
            transfer = 1'b1;
          end
        end
      end
      HOLD: begin
        bus.fd_valid = 1'b1;
        bus.fd_pc    = hold_pc;
        bus.fd_instr = hold_instr;
        if (!bus.fd_stall) begin
          transfer = 1'b1;
          state_d  = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      // NOTE: the hold buffer is reset even though HOLD always reloads it first;
      // a defined value keeps fd_pc/fd_instr deterministic out of reset.
      hold_pc      <= '0;
      hold_instr   <= '0;
      misalign_err <= 1'b0;
      fetch_cnt    <= '0;
    end else begin
      if (transfer) begin
        pc_q      <= next_pc;
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
      if (capture_hold) begin
        hold_pc    <= pc_q;
        hold_instr <= bus.imem_rdata;
      end
      if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00))
        misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a PC-stream model pushes expected fetch PCs,
// a monitor checks the imem address and every IF/ID delivery against them.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .misalign_err (misalign_err),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_rdata = mem_fn(bus.imem_addr);

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_pc;
  logic [31:0] ovr_pc;
  bit          ovr_v;
  bit          exp_mis;
  bit          active = 1'b0;
  int unsigned n_xfer;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_pc = RST_PC;
    exp_q.push_back(RST_PC);
    ovr_v   = 1'b0;
    ovr_pc  = '0;
    exp_mis = 1'b0;
    n_xfer  = 0;
  endtask

  // Drive one cycle of inputs (called at posedge+1) and advance the PC-stream model:
  // a redirect seen after d deliveries sets the PC of delivery d+1.
  task automatic cycle(input bit rdy, input bit stall, input bit rv, input logic [31:0] rpc);
    bit          xfer;
    logic [31:0] nxt;
    bus.imem_rdy       = rdy;
    bus.fd_stall       = stall;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(negedge clk);
    xfer = bus.fd_valid && !bus.fd_stall;
    if (rv) begin
      ovr_v  = 1'b1;
      ovr_pc = {rpc[31:2], 2'b00};
      if (rpc[1:0] != 2'b00) exp_mis = 1'b1;
    end
    if (xfer) begin
      nxt = ovr_v ? ovr_pc : last_pc + 32'd4;
      exp_q.push_back(nxt);
      last_pc = nxt;
      ovr_v   = 1'b0;
    end
    @(posedge clk);
    #1;
    check("misalign_err", {31'd0, misalign_err}, {31'd0, exp_mis});
  endtask

  initial begin : monitor
    logic        prev_wait;
    logic [31:0] prev_addr;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (active && !reset) begin
        if (exp_q.size() == 0) begin
          check("exp_queue_nonempty", 32'd0, 32'd1);
        end else begin
          if (bus.imem_req) begin
            check("imem_addr", bus.imem_addr, exp_q[0]);
            check("fd_valid_eq_rdy", {31'd0, bus.fd_valid}, {31'd0, bus.imem_rdy});
            if (prev_wait) check("imem_addr_stable", bus.imem_addr, prev_addr);
          end
          if (bus.fd_valid) begin
            check("fd_pc", bus.fd_pc, exp_q[0]);
            check("fd_instr", bus.fd_instr, mem_fn(exp_q[0]));
            if (!bus.fd_stall) begin
              check("fetch_cnt_at_xfer", fetch_cnt, n_xfer);
              n_xfer++;
              void'(exp_q.pop_front());
            end
          end
        end
        prev_wait = bus.imem_req && !bus.imem_rdy;
        prev_addr = bus.imem_addr;
      end else begin
        prev_wait = 1'b0;
      end
    end
  end

  initial begin : driver
    bit          rdy, stall, rv;
    logic [31:0] rpc;
    int unsigned sel;
    bus.imem_rdy       = 1'b0;
    bus.fd_stall       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_fd_valid", {31'd0, bus.fd_valid}, 32'd0);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    reset  = 1'b0;
    active = 1'b1;
    @(negedge clk);
    check("boot_no_req", {31'd0, bus.imem_req}, 32'd0);
    @(posedge clk);
    #1;
    check("first_req", {31'd0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr, RST_PC);

    // Back-to-back fetches, then a slow return, then a stalled delivery.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);
    check("cnt_after_3", fetch_cnt, 32'd3);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("hold_no_req", {31'd0, bus.imem_req}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    // Redirect while the delay-slot fetch waits, same-cycle redirect, misaligned target.
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_4000);
    cycle(1'b0, 1'b0, 1'b0, '0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_5000);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_4002);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);

    for (int i = 0; i < 2500; i++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      rv    = 1'b0;
      rpc   = '0;
      if ($urandom_range(0, 7) == 0) begin
        if (!ovr_v) begin
          rv = 1'b1;
        end else if ($urandom_range(0, 1) == 1) begin
          // Overwrite a buffered redirect only in a cycle that cannot transfer.
          rv    = 1'b1;
          stall = 1'b1;
        end
        sel = $urandom_range(0, 15);
        if (sel == 0)      rpc = 32'hFFFF_FFF8;
        else if (sel == 1) rpc = 32'h0000_4002 + ($urandom_range(0, 1023) << 2);
        else               rpc = 32'h0000_4000 + ($urandom_range(0, 1023) << 2);
      end
      cycle(rdy, stall, rv, rpc);
    end

    // Reset mid-fetch with a redirect buffered.
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_6000);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("async_rst_valid", {31'd0, bus.fd_valid}, 32'd0);
    check("async_rst_cnt", fetch_cnt, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) cycle(1'b1, 1'b0, 1'b0, '0);
    check("cnt_after_restart", fetch_cnt, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
